fp_add_pipe: RTL

//  Parametrised, 3-stage pipelined IEEE-style floating-point adder/subtractor with valid/ready handshake.

---
 rtl/fp_add_pipe_if.sv | 28 ++
 rtl/fp_add_pipe.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fp_add_pipe_if.sv
// Operand/result handshake bundle for fp_add_pipe; the adder connects through the slave modport.
interface fp_add_pipe_if #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic         op_sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         ovf;
   logic         zero;

   modport master (
      output in_valid, op_sub, a, b, out_ready,
      input  in_ready, out_valid, sum, ovf, zero
   );

   modport slave (
      input  in_valid, op_sub, a, b, out_ready,
      output in_ready, out_valid, sum, ovf, zero
   );
endinterface

// File: rtl/fp_add_pipe.sv
// 3-stage pipelined floating-point adder/subtractor (align, add, normalize/round) with valid/ready.
// Define FP_ADD_RNE_EN for round-to-nearest-even; default build truncates toward zero.
module fp_add_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   fp_add_pipe_if.slave bus
);
   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int FW  = MAN_W + 4;
   localparam int LZW = $clog2(FW + 1);
   localparam int XW  = EXP_W + 2;
   localparam logic [EXP_W-1:0] EXP_ONES = '1;
`ifdef FP_ADD_RNE_EN
   localparam bit RNE = 1'b1;
`else
   localparam bit RNE = 1'b0;
`endif

   function automatic logic [LZW-1:0] count_lz(input logic [FW-1:0] v);
      count_lz = '0;
      for (int i = 0; i < FW; i++)
         if (v[i]) count_lz = LZW'(FW - 1 - i);
   endfunction

   logic v1, v2, v3, advance;
   assign advance       = ~(v3 & ~bus.out_ready);
   assign bus.in_ready  = advance;
   assign bus.out_valid = v3;

   logic             sa, sb, a_zero, b_zero, a_inf, b_inf, a_big;
   logic [EXP_W-1:0] ea, eb, ex, ey, diff;
   logic [MAN_W-1:0] ma, mb;
   logic             sx, sy, sticky, sp, sp_zero;
   logic [FW-1:0]    mx_full, my_full, my_al;
   logic [W-1:0]     sp_sum;

   assign sa     = bus.a[W-1];
   assign ea     = bus.a[W-2:MAN_W];
   assign ma     = bus.a[MAN_W-1:0];
   assign sb     = bus.b[W-1] ^ bus.op_sub;
   assign eb     = bus.b[W-2:MAN_W];
   assign mb     = bus.b[MAN_W-1:0];
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (ea == EXP_ONES);
   assign b_inf  = (eb == EXP_ONES);

   // Zero and infinity operands bypass the arithmetic and ride the pipe as a finished result.
   always_comb begin
      a_big   = {ea, ma} >= {eb, mb};
      sx      = a_big ? sa : sb;
      sy      = a_big ? sb : sa;
      ex      = a_big ? ea : eb;
      ey      = a_big ? eb : ea;
      mx_full = {1'b1, (a_big ? ma : mb), 3'b000};
      my_full = {1'b1, (a_big ? mb : ma), 3'b000};
      diff    = ex - ey;
      sticky  = |(my_full & ~({FW{1'b1}} << diff));
      my_al   = (my_full >> diff) | {{(FW-1){1'b0}}, sticky};
      sp      = 1'b1;
      sp_zero = 1'b0;
      sp_sum  = '0;
      if (a_inf | b_inf)
         sp_sum = {((a_inf & b_inf) ? (sa & sb) : (a_inf ? sa : sb)), EXP_ONES, {MAN_W{1'b0}}};
      else if (a_zero & b_zero) begin
         sp_sum  = {sa & sb, {(W-1){1'b0}}};
         sp_zero = 1'b1;
      end
      else if (a_zero)
         sp_sum = {sb, eb, mb};
      else if (b_zero)
         sp_sum = {sa, ea, ma};
      else
         sp = 1'b0;
   end

   logic             s1_sign, s1_sub, s1_sp, s1_sp_zero;
   logic [EXP_W-1:0] s1_exp;
   logic [FW-1:0]    s1_mx, s1_my;
   logic [W-1:0]     s1_sp_sum;
   logic             s2_sign, s2_sp, s2_sp_zero;
   logic [EXP_W-1:0] s2_exp;
   logic [FW:0]      s2_r;
   logic [W-1:0]     s2_sp_sum;

   logic [LZW-1:0]   lz;
   logic [XW-1:0]    ee;
   logic [FW-1:0]    m;
   logic             up;
   logic [MAN_W+1:0] rnd;
   logic [W-1:0]     res_sum;
   logic             res_ovf, res_zero;

   // Carry-out shifts right folding the lost bit into sticky; otherwise renormalise left.
   always_comb begin
      lz = count_lz(s2_r[FW-1:0]);
      if (s2_r[FW]) begin
         m  = {s2_r[FW:2], s2_r[1] | s2_r[0]};
         ee = {2'b00, s2_exp} + XW'(1);
      end
      else begin
         m  = s2_r[FW-1:0] << lz;
         ee = {2'b00, s2_exp} - {{(XW-LZW){1'b0}}, lz};
      end
      up  = RNE & m[2] & (m[1] | m[0] | m[3]);
      rnd = {1'b0, m[FW-1:3]} + {{(MAN_W+1){1'b0}}, up};
      if (rnd[MAN_W+1]) ee = ee + XW'(1);
      res_sum  = {s2_sign, ee[EXP_W-1:0], rnd[MAN_W-1:0]};
      res_ovf  = 1'b0;
      res_zero = 1'b0;
      if (s2_sp) begin
         res_sum  = s2_sp_sum;
         res_zero = s2_sp_zero;
      end
      else if (s2_r == '0) begin
         res_sum  = '0;
         res_zero = 1'b1;
      end
      else if (!ee[XW-1] && ee >= XW'((1 << EXP_W) - 1)) begin
         res_sum = {s2_sign, EXP_ONES, {MAN_W{1'b0}}};
         res_ovf = 1'b1;
      end
      else if (ee[XW-1] || ee == '0) begin
         res_sum  = '0;
         res_zero = 1'b1;
      end
   end

   // All three stages move together; a stalled output freezes the whole pipe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
         s1_sign <= 1'b0; s1_sub <= 1'b0; s1_sp <= 1'b0; s1_sp_zero <= 1'b0;
         s1_exp <= '0; s1_mx <= '0; s1_my <= '0; s1_sp_sum <= '0;
         s2_sign <= 1'b0; s2_sp <= 1'b0; s2_sp_zero <= 1'b0;
         s2_exp <= '0; s2_r <= '0; s2_sp_sum <= '0;
         bus.sum <= '0; bus.ovf <= 1'b0; bus.zero <= 1'b0;
      end
      else if (advance) begin
         v1         <= bus.in_valid;
         v2         <= v1;
         v3         <= v2;
         s1_sign    <= sx;
         s1_sub     <= sx ^ sy;
         s1_exp     <= ex;
         s1_mx      <= mx_full;
         s1_my      <= my_al;
         s1_sp      <= sp;
         s1_sp_zero <= sp_zero;
         s1_sp_sum  <= sp_sum;
         s2_sign    <= s1_sign;
         s2_exp     <= s1_exp;
         s2_r       <= s1_sub ? ({1'b0, s1_mx} - {1'b0, s1_my}) : ({1'b0, s1_mx} + {1'b0, s1_my});
         s2_sp      <= s1_sp;
         s2_sp_zero <= s1_sp_zero;
         s2_sp_sum  <= s1_sp_sum;
         bus.sum    <= res_sum;
         bus.ovf    <= res_ovf;
         bus.zero   <= res_zero;
      end
   end
endmodule
